// File: rtl/instruction_queue_pkg.sv
// Shared types for the fetch -> decode instruction queue.
// The issue-entry struct is the same record that fetch produces.
package instruction_queue_pkg;

    localparam int ADDR_W = 17;
    localparam int INST_W = 32;

    typedef struct packed {
        logic [INST_W-1:0] instruction;
        logic              compressed;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] jalr_prediction;
        logic              br_prediction;
    } issue_entry_t;

endpackage

// File: rtl/instruction_queue_if.sv
// Fetch-side push handshake and decoder-side issue signals of the instruction queue.
// master = fetch/decoder environment, slave = the queue itself.
interface instruction_queue_if;
    import instruction_queue_pkg::*;

    logic              fetch_valid;
    logic [INST_W-1:0] fetch_instruction;
    logic              fetch_compressed;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_jalr_prediction;
    logic              fetch_br_prediction;
    logic              fetch_ready;

    logic              issue_stall;
    logic              instruction_in;
    logic [INST_W-1:0] instruction;
    logic              c_instruction;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] jalr_prediction;
    logic              br_prediction;
    logic              empty;

    modport master (
        output fetch_valid, fetch_instruction, fetch_compressed, fetch_pc,
               fetch_jalr_prediction, fetch_br_prediction, issue_stall,
        input  fetch_ready, instruction_in, instruction, c_instruction, pc,
               jalr_prediction, br_prediction, empty
    );

    modport slave (
        input  fetch_valid, fetch_instruction, fetch_compressed, fetch_pc,
               fetch_jalr_prediction, fetch_br_prediction, issue_stall,
        output fetch_ready, instruction_in, instruction, c_instruction, pc,
               jalr_prediction, br_prediction, empty
    );

endinterface

// File: rtl/instruction_queue.sv
// Circular FIFO buffering fetched instructions for the decoder; issues the oldest
// entry at most once per cycle and is emptied by a ROB flush.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rob_rst,
    instruction_queue_if.slave  iq
);

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [PTR_W:0]   count_reg, count_next;

    logic         full;
    logic         empty_int;
    logic         fetch_ready;
    logic         push;
    logic         pop;
    issue_entry_t fetch_entry;
    issue_entry_t head_entry;

    // Plain register array: the head must be readable in the same cycle it is indexed.
    issue_entry_t entry_mem [DEPTH];

    assign full        = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty_int   = (count_reg == '0);
    // Readiness ignores a same-cycle pop so the full check stays off the issue path.
    assign fetch_ready = !full && !rob_rst;
    assign push        = iq.fetch_valid && fetch_ready;
    assign pop         = !empty_int && !iq.issue_stall && !rob_rst;

    assign fetch_entry = '{
        instruction:     iq.fetch_instruction,
        compressed:      iq.fetch_compressed,
        pc:              iq.fetch_pc,
        jalr_prediction: iq.fetch_jalr_prediction,
        br_prediction:   iq.fetch_br_prediction
    };

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (rob_rst) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) tail_next = tail_reg + PTR_W'(1);
            if (pop)  head_next = head_reg + PTR_W'(1);
            count_next = count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry payload is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) entry_mem[tail_reg] <= fetch_entry;
    end

    assign head_entry = entry_mem[head_reg];

    assign iq.fetch_ready     = fetch_ready;
    assign iq.instruction_in  = pop;
    assign iq.empty           = empty_int;
    assign iq.instruction     = head_entry.instruction;
    assign iq.c_instruction   = head_entry.compressed;
    assign iq.pc              = head_entry.pc;
    assign iq.jalr_prediction = head_entry.jalr_prediction;
    assign iq.br_prediction   = head_entry.br_prediction;

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: directed scenarios plus random traffic,
// all compared against a queue-based model of the buffered entries.
module tb_instruction_queue;
    import instruction_queue_pkg::*;

    localparam int DEPTH = 8;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rob_rst = 1'b0;

    instruction_queue_if iq();

    issue_entry_t fe;
    issue_entry_t dut_head;
    issue_entry_t mq[$];
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign iq.fetch_instruction     = fe.instruction;
    assign iq.fetch_compressed      = fe.compressed;
    assign iq.fetch_pc              = fe.pc;
    assign iq.fetch_jalr_prediction = fe.jalr_prediction;
    assign iq.fetch_br_prediction   = fe.br_prediction;
    assign dut_head = {iq.instruction, iq.c_instruction, iq.pc, iq.jalr_prediction, iq.br_prediction};

    instruction_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rob_rst (rob_rst),
        .iq      (iq)
    );

    // Model expectations derived from the queue occupancy and current inputs.
    function automatic logic exp_ready();
        return (mq.size() != DEPTH) && !rob_rst;
    endfunction
    function automatic logic exp_in();
        return (mq.size() != 0) && !iq.issue_stall && !rob_rst;
    endfunction
    function automatic logic exp_empty();
        return (mq.size() == 0);
    endfunction

    function automatic issue_entry_t rand_entry();
        issue_entry_t e;
        e.instruction     = $urandom;
        e.compressed      = 1'($urandom_range(0, 1));
        e.pc              = 17'($urandom);
        e.jalr_prediction = 17'($urandom);
        e.br_prediction   = 1'($urandom_range(0, 1));
        return e;
    endfunction

    task automatic drive(input logic v, input logic st, input logic fl, input issue_entry_t e);
        iq.fetch_valid = v;
        iq.issue_stall = st;
        rob_rst        = fl;
        fe             = e;
        #1;
    endtask

    // Advance one clock edge and update the model from the inputs in force before it.
    task automatic tick();
        bit do_push = iq.fetch_valid && (mq.size() != DEPTH) && !rob_rst;
        bit do_pop  = (mq.size() != 0) && !iq.issue_stall && !rob_rst;
        bit do_fl   = rob_rst;
        issue_entry_t pushed = fe;
        @(posedge clk);
        if (do_fl) begin
            mq.delete();
            $display("t=%0t flush", $time);
        end else begin
            if (do_pop) begin
                $display("t=%0t issue pc=%05h inst=%08h", $time, mq[0].pc, mq[0].instruction);
                void'(mq.pop_front());
            end
            if (do_push) begin
                mq.push_back(pushed);
                $display("t=%0t push  pc=%05h inst=%08h", $time, pushed.pc, pushed.instruction);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, '0);
        #2;
        vectors++;
        if ({iq.fetch_ready, iq.instruction_in, iq.empty} !== 3'b101) begin
            errors++;
            $display("FAIL reset_ctl: got rdy/in/empty=%b required 101",
                     {iq.fetch_ready, iq.instruction_in, iq.empty});
        end
        rob_rst = 1'b1;
        #1;
        vectors++;
        if (iq.fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_flush: got %b required 0", iq.fetch_ready);
        end
        rob_rst = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_issue();
        issue_entry_t e;
        for (int k = 0; k < 6; k++) begin
            e = rand_entry();
            e.pc = 17'(4 * k);
            drive(k < 3, 1'b0, 1'b0, e);
            vectors++;
            if (iq.instruction_in !== ((k >= 1) && (k <= 3))) begin
                errors++;
                $display("FAIL basic_in cyc %0d: got %b required %b", k, iq.instruction_in, (k >= 1) && (k <= 3));
            end
            if ((k >= 1) && (k <= 3)) begin
                vectors++;
                if (iq.pc !== 17'(4 * (k - 1))) begin
                    errors++;
                    $display("FAIL basic_pc cyc %0d: got %05h required %05h", k, iq.pc, 4 * (k - 1));
                end
            end
            tick();
        end
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 1'b0, rand_entry());
            vectors++;
            if ({iq.fetch_ready, iq.instruction_in, iq.empty} !== {exp_ready(), exp_in(), exp_empty()}) begin
                errors++;
                $display("FAIL full_ctl cyc %0d: got rdy/in/empty=%b required %b", i,
                         {iq.fetch_ready, iq.instruction_in, iq.empty}, {exp_ready(), exp_in(), exp_empty()});
            end
            if (i == 8) begin
                vectors++;
                if (iq.fetch_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready9: got %b required 0", iq.fetch_ready);
                end
            end
            tick();
        end
    endtask

    task automatic test_full_push_pop();
        issue_entry_t e = rand_entry();
        e.pc = 17'h1EEEE;
        drive(1'b1, 1'b0, 1'b0, e);
        vectors++;
        if ({iq.fetch_ready, iq.instruction_in} !== 2'b01) begin
            errors++;
            $display("FAIL fullpp_ctl: got rdy/in=%b required 01", {iq.fetch_ready, iq.instruction_in});
        end
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, (i == 0), 1'b0, rand_entry());
            vectors++;
            if ({iq.fetch_ready, iq.instruction_in, iq.empty} !== {exp_ready(), exp_in(), exp_empty()}) begin
                errors++;
                $display("FAIL fullpp_drain cyc %0d: got rdy/in/empty=%b required %b", i,
                         {iq.fetch_ready, iq.instruction_in, iq.empty}, {exp_ready(), exp_in(), exp_empty()});
            end
            if (exp_in()) begin
                vectors++;
                if (dut_head !== mq[0]) begin
                    errors++;
                    $display("FAIL fullpp_head cyc %0d: got %h required %h", i, dut_head, mq[0]);
                end
            end
            tick();
        end
        vectors++;
        if (iq.empty !== 1'b1) begin
            errors++;
            $display("FAIL fullpp_empty: got %b required 1", iq.empty);
        end
    endtask

    task automatic test_wraparound();
        issue_entry_t e;
        for (int i = 0; i < 23; i++) begin
            e = rand_entry();
            e.pc              = 17'(17'h100 + 4 * i);
            e.br_prediction   = 1'(i % 2);
            e.jalr_prediction = 17'h1FFFF;
            drive(i < 20, 1'b0, 1'b0, e);
            vectors++;
            if ({iq.fetch_ready, iq.instruction_in, iq.empty} !== {exp_ready(), exp_in(), exp_empty()}) begin
                errors++;
                $display("FAIL wrap_ctl cyc %0d: got rdy/in/empty=%b required %b", i,
                         {iq.fetch_ready, iq.instruction_in, iq.empty}, {exp_ready(), exp_in(), exp_empty()});
            end
            if (exp_in()) begin
                vectors++;
                if (dut_head !== mq[0]) begin
                    errors++;
                    $display("FAIL wrap_head cyc %0d: got %h required %h", i, dut_head, mq[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        issue_entry_t e;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, rand_entry());
            tick();
        end
        e = rand_entry();
        e.pc = 17'h1ABCD;
        drive(1'b1, 1'b0, 1'b1, e);
        vectors++;
        if ({iq.fetch_ready, iq.instruction_in} !== 2'b00) begin
            errors++;
            $display("FAIL flush_ctl: got rdy/in=%b required 00", {iq.fetch_ready, iq.instruction_in});
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, rand_entry());
        vectors++;
        if ({iq.empty, iq.instruction_in} !== 2'b10) begin
            errors++;
            $display("FAIL flush_empty: got empty/in=%b required 10", {iq.empty, iq.instruction_in});
        end
        for (int i = 0; i < 4; i++) begin
            drive(i < 2, 1'b0, 1'b0, rand_entry());
            vectors++;
            if ({iq.fetch_ready, iq.instruction_in, iq.empty} !== {exp_ready(), exp_in(), exp_empty()}) begin
                errors++;
                $display("FAIL flush_after cyc %0d: got rdy/in/empty=%b required %b", i,
                         {iq.fetch_ready, iq.instruction_in, iq.empty}, {exp_ready(), exp_in(), exp_empty()});
            end
            if (exp_in()) begin
                vectors++;
                if (dut_head !== mq[0]) begin
                    errors++;
                    $display("FAIL flush_head cyc %0d: got %h required %h", i, dut_head, mq[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, rand_entry());
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, rand_entry());
        vectors++;
        if (iq.instruction_in !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre_in: got %b required 1", iq.instruction_in);
        end
        #1;
        rst_n = 1'b0;
        #1;
        mq.delete();
        vectors++;
        if ({iq.empty, iq.instruction_in, iq.fetch_ready} !== 3'b101) begin
            errors++;
            $display("FAIL arst_now: got empty/in/rdy=%b required 101", {iq.empty, iq.instruction_in, iq.fetch_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, 1'b0, 1'b0, rand_entry());
            vectors++;
            if (iq.instruction_in !== (i == 1)) begin
                errors++;
                $display("FAIL arst_after_in cyc %0d: got %b required %b", i, iq.instruction_in, i == 1);
            end
            if (exp_in()) begin
                vectors++;
                if (dut_head !== mq[0]) begin
                    errors++;
                    $display("FAIL arst_after_head cyc %0d: got %h required %h", i, dut_head, mq[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0, rand_entry());
            vectors++;
            if ({iq.fetch_ready, iq.instruction_in, iq.empty} !== {exp_ready(), exp_in(), exp_empty()}) begin
                errors++;
                $display("FAIL rand_ctl cyc %0d: got rdy/in/empty=%b required %b", i,
                         {iq.fetch_ready, iq.instruction_in, iq.empty}, {exp_ready(), exp_in(), exp_empty()});
            end
            if (exp_in()) begin
                vectors++;
                if (dut_head !== mq[0]) begin
                    errors++;
                    $display("FAIL rand_head cyc %0d: got %h required %h", i, dut_head, mq[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        iq.fetch_valid = 1'b0;
        iq.issue_stall = 1'b0;
        fe = '0;
        test_reset();
        test_basic_issue();
        test_full_stall();
        test_full_push_pop();
        test_wraparound();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
